scpu_byte_mem_responder: RTL and testbench
==========================================

// Module: scpu_byte_mem_responder
// PURPOSE
//  Memory-side responder for the serial CPU's byte-wide instruction/data bus.
//  Holds DEPTH 16-bit words and answers 8-bit CPU reads as two consecutive bytes, low byte first.
//  Assembles two consecutive 8-bit CPU write bytes into one 16-bit word commit.
//  Has a 16-bit preload port for the bench/loader. Used as either I-mem or D-mem beside SERIAL_CPU_8BIT.
// PARAMETERS
//  ADDR_W  9    word address width (matches CPU i_addr/d_addr)
//  DEPTH   512  implemented words; addr >= DEPTH is out of range
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  addr        in   ADDR_W  word address; sampled on the rd_req/first-we cycle only
//  rd_req      in   1       1-cycle read request
//  rd_data     out  8       returned byte
//  rd_valid    out  1       rd_data valid this cycle
//  we          in   1       write strobe; must be held 2 cycles (low byte, then high byte)
//  wr_data     in   8       write byte
//  wr_abort    out  1       1-cycle pulse: write sequence broken, nothing committed
//  busy        out  1       high in any state other than IDLE
//  load_en     in   1       preload strobe, 16-bit direct write
//  load_addr   in   ADDR_W  preload address
//  load_word   in   16      preload data
// BEHAVIOUR
//  Reset: state=IDLE; rd_data=8'h00, rd_valid=0, wr_abort=0, busy=0; holding regs cleared.
//   RAM contents are NOT cleared. Reset mid-sequence drops the sequence with no commit.
//  States are IDLE, RD_HI, WR_HI.
//  IDLE:
//   we=1: latch addr and low byte -> WR_HI. we has priority; simultaneous rd_req is dropped.
//   else rd_req=1: read word mem[addr] -> RD_HI.
//    Next cycle: rd_data=word[7:0], rd_valid=1.
//  RD_HI:
//   rd_data=word[15:8], rd_valid=1 -> IDLE. Latency: low byte at T+1, high byte at T+2 after the rd_req cycle T.
//   rd_req/we arriving in RD_HI are ignored (not queued).
//   Back-to-back reads therefore issue every 2 cycles.
//  WR_HI:
//   we=1: commit mem[latched addr] = {wr_data, low byte} at this edge -> IDLE.
//   we=0: no commit; wr_abort=1 for 1 cycle -> IDLE.
//   rd_req is ignored in WR_HI.
//  Visibility: a read whose rd_req is sampled on the cycle after the commit edge returns the new word.
//  Out of range (addr >= DEPTH):
//   Reads return 8'h00 for both bytes, with normal rd_valid timing.
//   Writes run the normal handshake but do not commit.
//  Preload: load_en writes mem[load_addr]=load_word in any state, same edge.
//   If it collides with a WR_HI commit to the same address, the CPU commit wins.
//   load_addr >= DEPTH is dropped.
//   A read already in RD_HI returns the word captured at rd_req; preload does not alter it.
//  rd_valid=0 and rd_data=8'h00 in all cycles not listed above.
//  All outputs are registered.
// TESTING
//  1. Preload addr0=16'h10AB; rd_req at addr0 -> cycle+1: rd_data=AB, rd_valid=1; cycle+2: rd_data=10; then rd_valid=0.
//  2. we=1 for 2 cycles at addr2 with bytes AB then 4C -> read addr2 returns AB then 4C (word 16'h4CAB); busy=1 only during WR_HI.
//  3. Preload addr3=16'h1234; we=1 with AB, then we=0 -> wr_abort pulses 1 cycle; read addr3 still returns 34,12.
//  4. rd_req and we both high in IDLE at addr4, bytes 55 then AA -> write wins, no rd_valid; later read gives 55,AA.
//  5. rd_req held 4 cycles at addr0 (preloaded 16'h10AB) -> bytes AB,10,AB,10; second request taken only from IDLE.
//  6. Assert rst between the low and high read bytes -> rd_valid=0 immediately (async); after release, busy=0 and RAM still holds 16'h10AB.
//  7. DEPTH=256: read addr 9'h1FF -> 00,00 with rd_valid; write to 9'h1FF does not alias onto addr 8'hFF.

Source files
------------

// File: rtl/scpu_byte_mem_responder.sv
// Word-organised memory that serves the serial CPU's byte-wide bus: 16-bit words
// are read back as two bytes (low first) and written as two consecutive bytes.
module scpu_byte_mem_responder #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_req,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              we,
    input  logic [7:0]        wr_data,
    output logic              wr_abort,
    output logic              busy,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_word
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {IDLE, RD_HI, WR_HI} state_t;

    state_t            state, state_nx;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_lo;
    logic [7:0]        rd_hi_byte;
    logic              start_rd, start_wr, commit, abort;
    logic              addr_ok, wr_addr_ok, load_ok;
    logic [15:0]       rd_word;

    // Range checks are done one bit wider so DEPTH == 2**ADDR_W stays representable.
    assign addr_ok    = {1'b0, addr} < DEPTH_V;
    assign wr_addr_ok = {1'b0, wr_addr} < DEPTH_V;
    assign load_ok    = {1'b0, load_addr} < DEPTH_V;
    assign rd_word    = addr_ok ? mem[addr[IDX_W-1:0]] : 16'h0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_rd = 1'b0;
        start_wr = 1'b0;
        commit   = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (we) begin
                    start_wr = 1'b1;
                    state_nx = WR_HI;
                end else if (rd_req) begin
                    start_rd = 1'b1;
                    state_nx = RD_HI;
                end
            end
            RD_HI: state_nx = IDLE;
            WR_HI: begin
                state_nx = IDLE;
                if (we) commit = 1'b1;
                else    abort  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The CPU commit is written last so it wins a same-address collision with preload.
    always_ff @(posedge clk) begin
        if (load_en && load_ok)
            mem[load_addr[IDX_W-1:0]] <= load_word;
        if (commit && wr_addr_ok)
            mem[wr_addr[IDX_W-1:0]] <= {wr_data, wr_lo};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data    <= 8'h00;
            rd_valid   <= 1'b0;
            rd_hi_byte <= 8'h00;
            wr_addr    <= '0;
            wr_lo      <= 8'h00;
            wr_abort   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rd_valid <= start_rd || (state == RD_HI);
            wr_abort <= abort;
            busy     <= (state_nx != IDLE);
            if (start_rd) begin
                rd_data    <= rd_word[7:0];
                rd_hi_byte <= rd_word[15:8];
            end else if (state == RD_HI) begin
                rd_data <= rd_hi_byte;
            end else begin
                rd_data <= 8'h00;
            end
            if (start_wr) begin
                wr_addr <= addr;
                wr_lo   <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_scpu_byte_mem_responder.sv
// Directed and randomized checks of the byte-wide memory responder against a
// word-array model of the memory and the byte-serial protocol timing.
module tb_scpu_byte_mem_responder;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic              rd_req;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              we;
    logic [7:0]        wr_data;
    logic              wr_abort;
    logic              busy;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [15:0]       load_word;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model [0:511];

    scpu_byte_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .we(we), .wr_data(wr_data), .wr_abort(wr_abort),
        .busy(busy), .load_en(load_en), .load_addr(load_addr), .load_word(load_word)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_word(input int a);
        return (a < DEPTH) ? model[a] : 16'h0000;
    endfunction

    task automatic preload(input int a, input logic [15:0] w);
        load_en = 1'b1; load_addr = a[ADDR_W-1:0]; load_word = w;
        tick;
        load_en = 1'b0;
        if (a < DEPTH) model[a] = w;
    endtask

    task automatic do_read(input string tag, input int a);
        logic [15:0] w;
        w = model_word(a);
        addr = a[ADDR_W-1:0]; rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
        chk({tag, "_lo_valid"}, rd_valid, 1'b1);
        chk({tag, "_lo"}, rd_data, w[7:0]);
        chk({tag, "_busy"}, busy, 1'b1);
        tick;
        chk({tag, "_hi_valid"}, rd_valid, 1'b1);
        chk({tag, "_hi"}, rd_data, w[15:8]);
        tick;
        chk({tag, "_done_valid"}, rd_valid, 1'b0);
        chk({tag, "_done_data"}, rd_data, 8'h00);
    endtask

    task automatic do_write(input string tag, input int a, input logic [7:0] lo, input logic [7:0] hi);
        addr = a[ADDR_W-1:0]; we = 1'b1; wr_data = lo;
        tick;
        chk({tag, "_busy_wrhi"}, busy, 1'b1);
        addr = ~addr;
        wr_data = hi;
        tick;
        we = 1'b0;
        chk({tag, "_busy_idle"}, busy, 1'b0);
        chk({tag, "_no_abort"}, wr_abort, 1'b0);
        if (a < DEPTH) model[a] = {hi, lo};
    endtask

    task automatic do_abort(input string tag, input int a, input logic [7:0] lo);
        addr = a[ADDR_W-1:0]; we = 1'b1; wr_data = lo;
        tick;
        we = 1'b0;
        tick;
        chk({tag, "_abort"}, wr_abort, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        tick;
        chk({tag, "_abort_clr"}, wr_abort, 1'b0);
    endtask

    initial begin
        int op, a;
        rst = 1'b1; addr = '0; rd_req = 1'b0; we = 1'b0; wr_data = 8'h00;
        load_en = 1'b0; load_addr = '0; load_word = 16'h0000;
        for (int i = 0; i < 512; i++) model[i] = 16'h0000;
        #12;
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_wr_abort", wr_abort, 1'b0);
        @(posedge clk); #1; rst = 1'b0;
        tick;

        // Basic preload and read-back
        preload(0, 16'h10AB);
        do_read("t1", 0);

        // Two-byte write then read
        do_write("t2", 2, 8'hAB, 8'h4C);
        chk("t2_model", model[2], 16'h4CAB);
        do_read("t2_rd", 2);

        // Broken write leaves memory alone
        preload(3, 16'h1234);
        do_abort("t3", 3, 8'hAB);
        do_read("t3_rd", 3);

        // Write wins over a simultaneous read
        addr = 9'd4; we = 1'b1; rd_req = 1'b1; wr_data = 8'h55;
        tick;
        rd_req = 1'b0;
        chk("t4_no_valid1", rd_valid, 1'b0);
        wr_data = 8'hAA;
        tick;
        we = 1'b0;
        chk("t4_no_valid2", rd_valid, 1'b0);
        model[4] = 16'hAA55;
        do_read("t4_rd", 4);

        // Held rd_req: second request only accepted from IDLE
        addr = 9'd0; rd_req = 1'b1;
        tick; chk("t5_b0", rd_data, 8'hAB); chk("t5_v0", rd_valid, 1'b1);
        tick; chk("t5_b1", rd_data, 8'h10); chk("t5_v1", rd_valid, 1'b1);
        tick; chk("t5_b2", rd_data, 8'hAB); chk("t5_v2", rd_valid, 1'b1);
        tick; chk("t5_b3", rd_data, 8'h10); chk("t5_v3", rd_valid, 1'b1);
        rd_req = 1'b0;
        tick; chk("t5_end", rd_valid, 1'b0);

        // Asynchronous reset between the two read bytes
        addr = 9'd0; rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
        chk("t6_lo", rd_data, 8'hAB);
        rst = 1'b1;
        #2;
        chk("t6_async_valid", rd_valid, 1'b0);
        chk("t6_async_busy", busy, 1'b0);
        @(posedge clk); #1; rst = 1'b0;
        tick;
        chk("t6_busy_after", busy, 1'b0);
        chk("t6_valid_after", rd_valid, 1'b0);
        do_read("t6_rd", 0);

        // Out-of-range addresses must not alias onto the implemented words
        preload(9'hFF, 16'hBEEF);
        do_read("t7_oor", 9'h1FF);
        do_write("t7_oor_wr", 9'h1FF, 8'h11, 8'h22);
        preload(9'h1FF, 16'h3333);
        do_read("t7_alias", 9'hFF);

        // Preload colliding with a commit to the same address
        addr = 9'd7; we = 1'b1; wr_data = 8'h77;
        tick;
        wr_data = 8'h66; load_en = 1'b1; load_addr = 9'd7; load_word = 16'hDEAD;
        tick;
        we = 1'b0; load_en = 1'b0;
        model[7] = 16'h6677;
        do_read("coll", 7);

        // Preload during RD_HI does not change the byte being returned
        addr = 9'd0; rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
        load_en = 1'b1; load_addr = 9'd0; load_word = 16'h5A5A;
        tick;
        load_en = 1'b0;
        chk("rdhi_preload_hi", rd_data, 8'h10);
        model[0] = 16'h5A5A;
        tick;
        do_read("rdhi_preload_new", 0);

        // Randomized mix against the word model
        for (int i = 0; i < 32; i++) preload(i, 16'($urandom));
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 3);
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(256, 511) : $urandom_range(0, 31);
            case (op)
                0: preload(a, 16'($urandom));
                1: do_write("rnd_wr", a, 8'($urandom), 8'($urandom));
                2: do_read("rnd_rd", a);
                default: do_abort("rnd_ab", a, 8'($urandom));
            endcase
        end
        for (int i = 0; i < 32; i += 5) do_read("rnd_final", i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
